// File: rtl/console_bus_writer.sv
// -----------------------------------------------------------------------------
// console_bus_writer
//
// Turns a byte stream of character codes into writes on the frame buffer's
// asynchronous RAM write port. The block owns the text cursor, interprets a
// small set of control codes (CR, LF, BS, FF), and mirrors the cursor into
// the frame buffer's cursor registers after every visible change.
//
// After reset it enables the hardware cursor, blanks the whole display and
// publishes cursor (0,0) before accepting characters.
//
// Ports
//   clock       system clock
//   reset       synchronous, active-high reset
//   char_data   character code from the source
//   char_valid  char_data valid; the source holds it until char_ready
//   char_ready  high while the block can accept a character
//   address     bus address
//   data_out    bus write data
//   data_oe     drive data_out onto the bus (high only during a write)
//   cs_ram_n    RAM chip select, active low
//   we_n        write enable, active low
//   cursor_col  current cursor column
//   cursor_row  current cursor row
//
// Each bus write is T_SETUP cycles of address/data before the strobe,
// T_STROBE cycles with cs_ram_n/we_n low, then T_HOLD cycles with the
// strobes released and address/data still stable.
// -----------------------------------------------------------------------------
module console_bus_writer #(
  parameter int BUS_DSIZE  = 8,
  parameter int BUS_ASIZE  = 12,
  parameter int REG_BASE   = 'h7F0,
  parameter int DISP_W     = 80,
  parameter int DISP_H     = 25,
  parameter int T_SETUP    = 2,
  parameter int T_STROBE   = 4,
  parameter int T_HOLD     = 8,
  parameter int BLANK_CHAR = 'h20
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                char_data,
  input  logic                      char_valid,
  output logic                      char_ready,
  output logic [BUS_ASIZE-1:0]      address,
  output logic [BUS_DSIZE-1:0]      data_out,
  output logic                      data_oe,
  output logic                      cs_ram_n,
  output logic                      we_n,
  output logic [$clog2(DISP_W)-1:0] cursor_col,
  output logic [$clog2(DISP_H)-1:0] cursor_row
);

  localparam int CW = $clog2(DISP_W);
  localparam int RW = $clog2(DISP_H);

  // Phase counter must hold the longest phase length minus one.
  localparam int T_MAX = (T_SETUP > T_STROBE) ?
                         ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD) :
                         ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
  localparam int CNT_W = $clog2(T_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_SETUP  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] CNT_STROBE = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] CNT_HOLD   = CNT_W'(T_HOLD - 1);

  localparam logic [BUS_ASIZE-1:0] A_CTRL   = BUS_ASIZE'(REG_BASE);
  localparam logic [BUS_ASIZE-1:0] A_COL    = BUS_ASIZE'(REG_BASE + 1);
  localparam logic [BUS_ASIZE-1:0] A_ROW    = BUS_ASIZE'(REG_BASE + 2);
  localparam logic [BUS_ASIZE-1:0] CLR_LAST = BUS_ASIZE'(DISP_W * DISP_H - 1);

  localparam logic [BUS_DSIZE-1:0] D_BLANK  = BUS_DSIZE'(BLANK_CHAR);
  localparam logic [BUS_DSIZE-1:0] D_CUR_EN = BUS_DSIZE'(8'h40);

  localparam logic [CW-1:0] COL_MAX = CW'(DISP_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(DISP_H - 1);

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_FF = 8'h0C;
  localparam logic [7:0] C_CR = 8'h0D;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CLEAR,
    ST_CUR_COL,
    ST_CUR_ROW,
    ST_IDLE,
    ST_DECODE,
    ST_CHAR_WR
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } phase_t;

  state_t                 state_q;
  phase_t                 phase_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BUS_ASIZE-1:0]   address_q;
  logic [BUS_DSIZE-1:0]   data_q;
  logic                   data_oe_q;   // also serves as "write in progress"
  logic                   cs_n_q;
  logic                   we_n_q;
  logic                   char_ready_q;
  logic [7:0]             char_q;
  logic [CW-1:0]          col_q;
  logic [RW-1:0]          row_q;
  logic [BUS_ASIZE-1:0]   clr_q;

  // Combinational helpers
  logic                   wr_done;     // last HOLD cycle of the current write
  logic                   wr_req;      // launch a write on this edge
  logic [BUS_ASIZE-1:0]   wr_addr_d;
  logic [BUS_DSIZE-1:0]   wr_data_d;
  logic [BUS_ASIZE-1:0]   pos_addr;
  logic [RW-1:0]          row_inc;
  logic                   is_print;

  assign char_ready = char_ready_q;
  assign address    = address_q;
  assign data_out   = data_q;
  assign data_oe    = data_oe_q;
  assign cs_ram_n   = cs_n_q;
  assign we_n       = we_n_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_comb begin
    // Linear display address at 32 bits before narrowing to the bus.
    pos_addr = BUS_ASIZE'(32'(row_q) * 32'(DISP_W) + 32'(col_q));
    row_inc  = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
    is_print = ((char_q >= 8'h20) && (char_q <= 8'h7E)) || char_q[7];
    wr_done  = data_oe_q && (phase_q == PH_HOLD) && (cnt_q == '0);
  end

  // Decide whether a write starts on this edge and what it carries. A new
  // write is only requested with the bus idle or on the final HOLD cycle, so
  // back-to-back writes run SETUP directly after HOLD.
  always_comb begin
    wr_req    = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    case (state_q)
      ST_INIT: begin
        if (!data_oe_q) begin
          wr_req    = 1'b1;
          wr_addr_d = A_CTRL;
          wr_data_d = D_CUR_EN;
        end else if (wr_done) begin
          wr_req    = 1'b1;
          wr_addr_d = '0;
          wr_data_d = D_BLANK;
        end
      end
      ST_CLEAR: begin
        if (wr_done) begin
          wr_req = 1'b1;
          if (clr_q == CLR_LAST) begin
            // Cursor is homed on this same edge, so the column is zero.
            wr_addr_d = A_COL;
            wr_data_d = '0;
          end else begin
            wr_addr_d = clr_q + BUS_ASIZE'(1);
            wr_data_d = D_BLANK;
          end
        end
      end
      ST_CUR_COL: begin
        if (wr_done) begin
          wr_req    = 1'b1;
          wr_addr_d = A_ROW;
          wr_data_d = BUS_DSIZE'(row_q);
        end
      end
      ST_DECODE: begin
        if (is_print) begin
          wr_req    = 1'b1;
          wr_addr_d = pos_addr;
          wr_data_d = BUS_DSIZE'(char_q);
        end else if (char_q == C_CR) begin
          wr_req    = 1'b1;
          wr_addr_d = A_COL;
          wr_data_d = '0;
        end else if (char_q == C_LF) begin
          wr_req    = 1'b1;
          wr_addr_d = A_COL;
          wr_data_d = BUS_DSIZE'(col_q);
        end else if ((char_q == C_BS) && (col_q != '0)) begin
          // Blank the cell left of the cursor (col > 0, so no underflow).
          wr_req    = 1'b1;
          wr_addr_d = pos_addr - BUS_ASIZE'(1);
          wr_data_d = D_BLANK;
        end else if (char_q == C_FF) begin
          wr_req    = 1'b1;
          wr_addr_d = '0;
          wr_data_d = D_BLANK;
        end
      end
      ST_CHAR_WR: begin
        if (wr_done) begin
          wr_req    = 1'b1;
          wr_addr_d = A_COL;
          wr_data_d = BUS_DSIZE'(col_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_INIT;
      phase_q      <= PH_SETUP;
      cnt_q        <= '0;
      address_q    <= '0;
      data_q       <= '0;
      data_oe_q    <= 1'b0;
      cs_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      char_ready_q <= 1'b0;
      char_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      clr_q        <= '0;
    end else begin
      // ---------------- bus write engine ----------------
      if (wr_req) begin
        address_q <= wr_addr_d;
        data_q    <= wr_data_d;
        data_oe_q <= 1'b1;
        cs_n_q    <= 1'b1;
        we_n_q    <= 1'b1;
        phase_q   <= PH_SETUP;
        cnt_q     <= CNT_SETUP;
      end else if (data_oe_q) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end else begin
          case (phase_q)
            PH_SETUP: begin
              phase_q <= PH_STROBE;
              cnt_q   <= CNT_STROBE;
              cs_n_q  <= 1'b0;
              we_n_q  <= 1'b0;
            end
            PH_STROBE: begin
              phase_q <= PH_HOLD;
              cnt_q   <= CNT_HOLD;
              cs_n_q  <= 1'b1;
              we_n_q  <= 1'b1;
            end
            default: begin
              // End of HOLD with nothing queued behind it: release the bus.
              data_oe_q <= 1'b0;
              phase_q   <= PH_SETUP;
            end
          endcase
        end
      end

      // ---------------- sequencer ----------------
      case (state_q)
        ST_INIT: begin
          if (wr_done) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
          end
        end
        ST_CLEAR: begin
          if (wr_done) begin
            if (clr_q == CLR_LAST) begin
              col_q   <= '0;
              row_q   <= '0;
              state_q <= ST_CUR_COL;
            end else begin
              clr_q <= clr_q + BUS_ASIZE'(1);
            end
          end
        end
        ST_CUR_COL: begin
          if (wr_done) state_q <= ST_CUR_ROW;
        end
        ST_CUR_ROW: begin
          if (wr_done) begin
            state_q      <= ST_IDLE;
            char_ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (char_valid && char_ready_q) begin
            char_q       <= char_data;
            char_ready_q <= 1'b0;
            state_q      <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_print) begin
            state_q <= ST_CHAR_WR;
            if (col_q == COL_MAX) begin
              col_q <= '0;
              row_q <= row_inc;
            end else begin
              col_q <= col_q + CW'(1);
            end
          end else begin
            case (char_q)
              C_CR: begin
                col_q   <= '0;
                state_q <= ST_CUR_COL;
              end
              C_LF: begin
                row_q   <= row_inc;
                state_q <= ST_CUR_COL;
              end
              C_BS: begin
                if (col_q != '0) begin
                  col_q   <= col_q - CW'(1);
                  state_q <= ST_CHAR_WR;
                end else begin
                  state_q      <= ST_IDLE;
                  char_ready_q <= 1'b1;
                end
              end
              C_FF: begin
                clr_q   <= '0;
                state_q <= ST_CLEAR;
              end
              default: begin
                state_q      <= ST_IDLE;
                char_ready_q <= 1'b1;
              end
            endcase
          end
        end
        ST_CHAR_WR: begin
          if (wr_done) state_q <= ST_CUR_COL;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: doc/console_bus_writer.md
Name: console_bus_writer

Overview:
- Bus initiator that drives the frame buffer's asynchronous RAM write port, turning a byte stream of characters into display-RAM and cursor-register writes.
- Owns the cursor position, handles common control codes, and keeps the frame buffer's cursor registers in step.
- Sits between a character source (UART receiver, test sequencer) and the frame buffer bus pins.

Parameters:
BUS_DSIZE, 8, bus data width
BUS_ASIZE, 12, bus address width
REG_BASE, 'h7F0, frame buffer register base (+0 ctrl, +1 cursor col, +2 cursor row)
DISP_W, 80, display width in characters
DISP_H, 25, display height in characters
T_SETUP, 2, cycles address/data are valid before strobe (>=1)
T_STROBE, 4, cycles cs_ram_n/we_n held low (>=1)
T_HOLD, 8, cycles address/data held after strobe release (>=4, covers the receiver's 3-stage sync)
BLANK_CHAR, 'h20, fill code for clear and backspace

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
char_data  in  8  character code
char_valid  in  1  char_data valid
char_ready  out  1  block can accept a character
address  out  BUS_ASIZE  bus address
data_out  out  BUS_DSIZE  bus write data
data_oe  out  1  drive data_out onto the bus
cs_ram_n  out  1  RAM chip select, active low
we_n  out  1  write enable, active low
cursor_col  out  clog2(DISP_W)  current cursor column
cursor_row  out  clog2(DISP_H)  current cursor row

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: cs_ram_n=1, we_n=1, data_oe=0, address=0, data_out=0, char_ready=0, cursor_col=0, cursor_row=0.
- Reset mid-operation aborts the current cycle. Strobes are high on the cycle after reset is sampled.
- Bus write cycle, exactly T_SETUP+T_STROBE+T_HOLD clocks:
  - SETUP: address/data_out driven, data_oe=1, cs_ram_n=we_n=1.
  - STROBE: cs_ram_n=we_n=0.
  - HOLD: strobes high, address/data unchanged.
  - Back-to-back writes: the next SETUP follows HOLD directly. Strobes are never low in two consecutive cycles that belong to different writes.
- data_oe=0 whenever no write is in progress. No bus reads are ever issued.
- States:
  - INIT: after reset, write REG_BASE+0 = 'h40 (cursor enable), then enter CLEAR.
  - CLEAR: write BLANK_CHAR to addresses 0..DISP_W*DISP_H-1 in ascending order, set cursor to (0,0), then enter CURSOR.
  - IDLE: char_ready=1. A character is accepted on char_valid&char_ready; char_ready goes 0 the next cycle.
  - DECODE: one cycle; selects the action below.
  - CHAR_WR: single display write.
  - CURSOR: write REG_BASE+1 = cursor_col, then REG_BASE+2 = cursor_row (zero-extended), then return to IDLE.
- Character actions (display address = row*DISP_W+col, computed at full width, no truncation):
  - 'h20..'h7E and 'h80..'hFF: write the code at the cursor, then col+1. If col was DISP_W-1: col=0, row+1. Row wraps DISP_H-1 -> 0 (no scroll).
  - 'h0D CR: col=0.
  - 'h0A LF: row+1 with wrap; col unchanged.
  - 'h08 BS: if col>0, col-1 then write BLANK_CHAR at the new position. If col=0, no bus writes and no cursor writes.
  - 'h0C FF: full CLEAR (no INIT write), cursor to (0,0).
  - Any other code: dropped, no bus activity, back to IDLE.
- Every action other than "dropped" and "BS at col 0" ends with the CURSOR sequence.
- cursor_col/cursor_row outputs update in DECODE/CHAR_WR, before the CURSOR writes begin.
- char_valid while char_ready=0 is ignored; the source must hold it.

Test Plan:
- Reset with defaults -> write 'h7F0='h40; 2000 writes of 'h20 to addresses 0..1999; then 'h7F1=0, 'h7F2=0; char_ready=1. Each write is 14 clocks, with strobes low exactly 4 clocks.
- From (0,0), send 'h41 -> writes addr 0='h41, 'h7F1=1, 'h7F2=0; cursor (1,0).
- Cursor at (79,24), send 'h5A -> write addr 1999='h5A; cursor registers written (0,0).
- Cursor at (5,3), send 'h08 -> addr 244='h20, cursor (4,3). Then at col 0, send 'h08 -> no bus activity; char_ready back high after the DECODE cycle.
- Send 'h0D then 'h0A from (10,24) -> cursor (0,24) then (0,0). Send 'h07 -> no writes.
- Assert reset during the STROBE of a character write -> cs_ram_n/we_n high on the next cycle, followed by a full INIT + CLEAR sequence.
